// File: rtl/fetch_unit.sv
// fetch_unit: LEGv8 fetch stage, one outstanding imem read, valid/ready instruction register.
// Define FETCH_PERF_CNT_EN to add saturating perf_fetched/perf_dropped counters.
module fetch_unit #(
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [10:0]       opCode,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_dropped
`endif
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DROP, HOLD} state_t;
  state_t state;
  logic [ADDR_W-1:0] pc, tgt;
  assign tgt = br_target & ~ADDR_W'(3);
  assign imem_req = state == ISSUE;
  assign imem_addr = pc;
  // if_instr is cleared whenever if_valid drops, so opCode decodes to 0 then
  assign opCode = if_instr[31:21];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc <= RESET_PC;
    end else begin
      if (br_taken) pc <= tgt;
      case (state)
        IDLE: state <= ISSUE;
        ISSUE: state <= br_taken ? DROP : WAIT;
        WAIT:
          if (imem_valid && !br_taken) begin
            if_instr <= imem_rdata;
            if_pc <= pc;
            pc <= pc + ADDR_W'(4);
            if_valid <= 1'b1;
            state <= HOLD;
          end else if (imem_valid) state <= ISSUE;
          else if (br_taken) state <= DROP;
        // a redirect coinciding with the stale response still reissues, at the new target
        DROP: if (imem_valid) state <= ISSUE;
        HOLD:
          if (br_taken || if_ready) begin
            if_valid <= 1'b0;
            if_instr <= '0;
            state <= ISSUE;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef FETCH_PERF_CNT_EN
  logic fetched_ev, dropped_ev;
  assign fetched_ev = state == HOLD && if_ready && !br_taken;
  assign dropped_ev = (state == HOLD && br_taken) || (imem_valid && (state == DROP || (state == WAIT && br_taken)));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      if (fetched_ev && !(&perf_fetched)) perf_fetched <= perf_fetched + 32'd1;
      if (dropped_ev && !(&perf_dropped)) perf_dropped <= perf_dropped + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: transaction-level model of fetch_unit (expected next PC, one outstanding read, memory image).
module tb_fetch_unit;
  localparam int AW = 64;
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req, if_valid;
  logic imem_valid = 1'b0, if_ready = 1'b0, br_taken = 1'b0;
  logic [AW-1:0] imem_addr, if_pc;
  logic [AW-1:0] br_target = '0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_instr;
  logic [10:0] opCode;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif
  int checks = 0, errors = 0;
  logic [AW-1:0] exp_pc = '0, pend_addr = '0;
  bit pend = 0, killed = 0, fixed = 0, rnd = 0, saw_req = 0, saw_valid = 0;
  int cnt = 0, mem_delay = 1, step_no = 0, accepted = 0, exp_fetched = 0, exp_dropped = 0;
  logic [AW-1:0] req_log[$];
  int acc_log[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc), .opCode(opCode),
    .br_taken(br_taken), .br_target(br_target)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return fixed ? 32'h8B020020 : ((a[31:0] * 32'h9E3779B1) ^ 32'h5A5A0000);
  endfunction

  task automatic model_reset;
    exp_pc = '0; pend = 0; killed = 0; cnt = 0; exp_fetched = 0; exp_dropped = 0;
  endtask

  // One clock: check current outputs against the model, then drive inputs for the next edge.
  task automatic step(input bit br, input logic [AW-1:0] tgt, input bit rdy, input bit spur);
    logic [31:0] exp_w;
    logic [10:0] exp_op;
    @(negedge clk);
    step_no++;
    saw_req = imem_req;
    saw_valid = if_valid;
    exp_w = if_valid ? mem_word(exp_pc) : 32'h0;
    exp_op = exp_w[31:21];
    checks++;
    if (if_instr !== exp_w || (if_valid && if_pc !== exp_pc)) begin
      errors++;
      $display("FAIL held_instr step %0d: valid=%b pc=%h instr=%h, expected pc=%h instr=%h", step_no, if_valid, if_pc, if_instr, exp_pc, exp_w);
    end
    checks++;
    if (opCode !== exp_op) begin
      errors++;
      $display("FAIL opcode step %0d: got %b expected %b", step_no, opCode, exp_op);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_fetched !== 32'(exp_fetched) || perf_dropped !== 32'(exp_dropped)) begin
      errors++;
      $display("FAIL perf step %0d: fetched=%0d dropped=%0d expected %0d %0d", step_no, perf_fetched, perf_dropped, exp_fetched, exp_dropped);
    end
`endif
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    if (imem_req) begin
      checks++;
      if (imem_addr !== exp_pc || pend || if_valid) begin
        errors++;
        $display("FAIL request step %0d: addr=%h outstanding=%b held=%b, expected addr=%h none outstanding", step_no, imem_addr, pend, if_valid, exp_pc);
      end
      pend = 1; pend_addr = imem_addr; killed = 0;
      cnt = rnd ? int'($urandom_range(1, 3)) : mem_delay;
      req_log.push_back(imem_addr);
    end else if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_valid = 1'b1;
        imem_rdata = mem_word(pend_addr);
        pend = 0;
        if (killed || br) exp_dropped++;
      end
    end else if (spur) imem_valid = 1'b1;
    if (br && pend) killed = 1;
    if (if_valid && rdy && !br) begin
      exp_pc = exp_pc + 64'd4;
      accepted++; exp_fetched++;
      acc_log.push_back(step_no);
    end
    if (if_valid && br) exp_dropped++;
    if (br) exp_pc = tgt & ~64'h3;
    br_taken = br; br_target = tgt; if_ready = rdy;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 64'h0 || if_pc !== 64'h0 || if_instr !== 32'h0 || opCode !== 11'h0) begin
      errors++;
      $display("FAIL reset: req=%b valid=%b addr=%h pc=%h instr=%h op=%h, expected all zero", imem_req, if_valid, imem_addr, if_pc, if_instr, opCode);
    end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_sequence;
    req_log.delete(); acc_log.delete();
    mem_delay = 1;
    repeat (9) step(0, '0, 1, 0);
    checks++;
    if (req_log.size() < 3 || req_log[0] !== 64'h0 || req_log[1] !== 64'h4 || req_log[2] !== 64'h8) begin
      errors++;
      $display("FAIL seq_addr: got %0d requests first=%h, expected 0x0 0x4 0x8", req_log.size(), req_log.size() > 0 ? req_log[0] : 64'hx);
    end
    checks++;
    if (acc_log.size() != 3 || acc_log[1] - acc_log[0] != 3 || acc_log[2] - acc_log[1] != 3) begin
      errors++;
      $display("FAIL seq_rate: got %0d accepts, expected 3 spaced 3 cycles apart", acc_log.size());
    end
  endtask

  task automatic test_opcode;
    int n = 0;
    fixed = 1;
    do begin step(0, '0, 0, 0); n++; end while (!saw_valid && n < 8);
    checks++;
    if (!saw_valid || opCode !== 11'b10001011000) begin
      errors++;
      $display("FAIL add_opcode: valid=%b op=%b expected valid=1 op=10001011000", saw_valid, opCode);
    end
  endtask

  task automatic test_stall;
    repeat (5) step(0, '0, 0, 0);
    checks++;
    if (!if_valid || if_pc !== 64'hC || if_instr !== 32'h8B020020) begin
      errors++;
      $display("FAIL stall: valid=%b pc=%h instr=%h expected 1 c 8b020020", if_valid, if_pc, if_instr);
    end
    step(0, '0, 1, 0);
    fixed = 0;
    step(0, '0, 0, 0);
    checks++;
    if (if_valid !== 1'b0 || opCode !== 11'h0) begin
      errors++;
      $display("FAIL after_accept: valid=%b op=%b expected 0 0", if_valid, opCode);
    end
  endtask

  task automatic test_branch_wait;
    int n = 0;
    bit any_valid = 0;
    mem_delay = 3;
    do begin step(0, '0, 1, 0); n++; end while (!saw_req && n < 8);
    step(1, 64'h40, 1, 0);
    n = 0;
    do begin step(0, '0, 1, 0); n++; any_valid |= saw_valid; end while (!saw_req && n < 10);
    checks++;
    if (!saw_req || req_log[$] !== 64'h40 || any_valid) begin
      errors++;
      $display("FAIL br_wait: req=%b addr=%h stale_valid=%b expected req at 40 no valid", saw_req, req_log[$], any_valid);
    end
  endtask

  task automatic test_branch_hold;
    int n = 0, a;
    mem_delay = 1;
    do begin step(0, '0, 0, 0); n++; end while (!saw_valid && n < 8);
    a = accepted;
    step(1, 64'h103, 1, 0);
    n = 0;
    do begin step(0, '0, 0, 0); n++; end while (!saw_req && n < 8);
    checks++;
    if (!saw_req || req_log[$] !== 64'h100 || accepted != a) begin
      errors++;
      $display("FAIL br_hold: req=%b addr=%h accepts=%0d expected req at 100 accepts=%0d", saw_req, req_log[$], accepted, a);
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    mem_delay = 4;
    do begin step(0, '0, 1, 0); n++; end while (!saw_req && n < 8);
    #7 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 64'h0 || if_valid !== 1'b0 || if_pc !== 64'h0 || if_instr !== 32'h0 || opCode !== 11'h0) begin
      errors++;
      $display("FAIL async_reset: req=%b addr=%h valid=%b pc=%h instr=%h expected reset values", imem_req, imem_addr, if_valid, if_pc, if_instr);
    end
    model_reset();
    imem_valid = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    rst_n = 1'b1;
    req_log.delete();
    repeat (6) step(0, '0, 1, 0);
    checks++;
    if (req_log.size() == 0 || req_log[0] !== 64'h0) begin
      errors++;
      $display("FAIL post_reset_addr: got %0d requests first=%h expected 0", req_log.size(), req_log.size() > 0 ? req_log[0] : 64'hx);
    end
  endtask

  task automatic test_random;
    int a = accepted;
    rnd = 1;
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) == 0, {$urandom, $urandom}, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
    rnd = 0;
    checks++;
    if (accepted - a < 20) begin
      errors++;
      $display("FAIL random_progress: accepted %0d expected at least 20", accepted - a);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_opcode();
    test_stall();
    test_branch_wait();
    test_branch_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
